jtframe_ioctl_upload: RTL and testbench
=======================================

Name: jtframe_ioctl_upload

Overview:
- Serves HPS upload (save/dump) reads: hps_io pulses ioctl_rd with an address; this block fetches bytes from a game-side 8-bit memory port and presents them on ioctl_din.
- Reverse direction of the ROM download path. In 16-bit (fast I/O) mode it packs two byte fetches into one 16-bit word, mirroring the download-side 16-to-8 split.
- Sits between hps_io and the core's NVRAM or high-score RAM, in the clk_rom domain.

Parameters:
- WIDE, 0, 1 = 16-bit ioctl_din (fast I/O), 0 = 8-bit.
- INDEX, 8'd2, ioctl_index value that selects this upload.
- AW, 12, game memory address width.
- SIZE, 4096, valid bytes; addresses at or above SIZE read 8'hFF.

Ports:
- clk_rom  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ioctl_upload  in  1  upload session active (from hps_io).
- ioctl_index  in  8  selected file index.
- ioctl_rd  in  1  one-cycle read strobe.
- ioctl_addr  in  27  byte address of the request (even when WIDE=1).
- ioctl_din  out  8/16  data returned to hps_io. Width is 16 if WIDE=1, else 8.
- mem_addr  out  AW  game memory byte address.
- mem_rd  out  1  read request, held high until mem_ok.
- mem_dout  in  8  game memory data, valid together with mem_ok.
- mem_ok  in  1  one-cycle acknowledge.
- hold  out  1  asks the game to freeze memory writes during the session.
- busy  out  1  a fetch is in progress.
- overrun  out  1  sticky flag: ioctl_rd arrived while one request was already queued.

Behaviour:
- Reset values: ioctl_din=0, mem_addr=0, mem_rd=0, hold=0, busy=0, overrun=0. FSM state is IDLE.
- Session: active = ioctl_upload && ioctl_index==INDEX, registered once.
  - hold=1 from the cycle after active rises to the cycle after it falls.
  - overrun clears when a new session starts.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - On ioctl_rd while active: latch ioctl_addr, go to LO, busy=1.
  - ioctl_rd while not active is ignored.
- LO (byte at addr):
  - If addr < SIZE: drive mem_addr=addr[AW-1:0] and mem_rd=1. When mem_ok arrives, capture mem_dout into lo and drop mem_rd the same cycle.
  - If addr >= SIZE: lo=8'hFF and no memory access; advance next cycle.
  - Next state is HI if WIDE, else DONE.
- HI (WIDE only): same as LO for addr+1, captured into hi.
- DONE:
  - Update ioctl_din to {hi,lo} (WIDE) or lo, exactly once per request. ioctl_din holds until the next DONE.
  - busy=0, return to IDLE.
- Latency with zero-wait memory (mem_ok the cycle after mem_rd):
  - ioctl_din is valid 3 cycles after ioctl_rd when WIDE=0, 5 cycles when WIDE=1.
  - hps_io re-samples no sooner than ~100 cycles, so this is well inside the budget.
- ioctl_rd while busy:
  - Queue one request (address latched). It starts the cycle after DONE.
  - A further ioctl_rd while the queue is full sets overrun and is dropped.
- Session end (active falls) mid-fetch:
  - mem_rd drops next cycle and the FSM returns to IDLE.
  - The queue is flushed and ioctl_din is left unchanged.
- Address arithmetic: addr+1 is computed at 27 bits; the SIZE comparison uses the full 27 bits, so there is no wrap-around into low memory.
- ioctl_rd and mem_ok in the same cycle: both are honoured.
- Asynchronous reset mid-operation returns every output to its reset value immediately.

Optional Feature:
- JTFRAME_UPLOAD_SUM_EN adds output sum[15:0].
- With the macro:
  - sum clears at session start.
  - In each DONE, the byte(s) just served are added modulo 2^16, 0xFF padding included. The value is stable while busy=0.
  - Purpose: the bench and the debug OSD can compare it against the host-side file sum.
- Without the macro: the port and adder are absent, and behaviour is otherwise identical.

Decomposition:
- Package jtframe_ioctl_pkg holds:
  - the FSM state enum (IDLE/LO/HI/DONE);
  - localparam IOCTL_AW=27;
  - localparam PAD_BYTE=8'hFF.
- Sub-module jtframe_ioctl_fetch: a single-byte fetch unit that issues mem_rd, waits for mem_ok, applies the SIZE padding and returns byte plus done. It is instantiated once and reused for LO and HI.

Test Plan:
- WIDE=0, memory[0x10]=8'hA5, ioctl_rd addr=0x10, mem_ok after 1 cycle -> ioctl_din=8'hA5 3 cycles after the strobe, busy high for exactly those cycles.
- WIDE=1, memory[0x20]=8'h34 and [0x21]=8'h12 -> ioctl_din=16'h1234, with two mem_rd pulses at addresses 0x20 then 0x21.
- WIDE=1, SIZE=4096, addr=4095 -> ioctl_din={8'hFF, mem[4095]}, one memory access only. Addr=0x7FFFFFE -> 16'hFFFF, no mem_rd.
- mem_ok delayed 10 cycles while ioctl_rd strikes twice more -> the first extra strobe is queued and served in order; the second sets overrun=1.
- ioctl_upload drops while mem_rd=1 -> mem_rd=0 next cycle, hold=0 the cycle after, ioctl_din unchanged. A new session clears overrun.
- With JTFRAME_UPLOAD_SUM_EN, dump of bytes 01,02,03,04 (WIDE=1) -> sum=16'h000A. Assert rst_n=0 mid-fetch -> all outputs are 0 asynchronously.

Source files
------------

// File: rtl/jtframe_ioctl_pkg.sv
// Shared types and constants for the HPS upload (save/dump) read path.
package jtframe_ioctl_pkg;

  localparam int unsigned IOCTL_AW = 27;
  localparam logic [7:0]  PAD_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

endpackage

// File: rtl/jtframe_ioctl_upload_if.sv
// Game-side 8-bit memory read port used by the upload block.
interface jtframe_ioctl_upload_if #(
  parameter int unsigned AW = 12
);

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_dout;
  logic          mem_ok;

  modport master (output mem_addr, mem_rd, input mem_dout, mem_ok);
  modport slave  (input mem_addr, mem_rd, output mem_dout, mem_ok);

endinterface

// File: rtl/jtframe_ioctl_fetch.sv
// Single-byte fetch unit: one memory read per start, or 0xFF padding past SIZE.
module jtframe_ioctl_fetch
  import jtframe_ioctl_pkg::*;
#(
  parameter int unsigned AW   = 12,
  parameter int unsigned SIZE = 4096
)(
  input  logic                  clk_rom,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IOCTL_AW-1:0]   addr,
  output logic [7:0]            data_c,
  output logic                  done_c,
  jtframe_ioctl_upload_if.master mem
);

  localparam logic [IOCTL_AW-1:0] LIMIT = IOCTL_AW'(SIZE);

  logic pad;

  assign done_c = pad | (mem.mem_rd & mem.mem_ok);
  assign data_c = pad ? PAD_BYTE : mem.mem_dout;

  // A start on the completing edge re-arms the request, so back-to-back bytes keep mem_rd high
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      pad          <= 1'b0;
    end else begin
      if (done_c || abort) begin
        mem.mem_rd <= 1'b0;
        pad        <= 1'b0;
      end
      if (start) begin
        if (addr < LIMIT) begin
          mem.mem_rd   <= 1'b1;
          mem.mem_addr <= addr[AW-1:0];
        end else begin
          pad <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jtframe_ioctl_upload.sv
// HPS upload read server: fetches 1 or 2 bytes per ioctl_rd and returns them on ioctl_din.
// Optional JTFRAME_UPLOAD_SUM_EN adds a running 16-bit sum of served bytes.
module jtframe_ioctl_upload
  import jtframe_ioctl_pkg::*;
#(
  parameter int unsigned WIDE  = 0,
  parameter logic [7:0]  INDEX = 8'd2,
  parameter int unsigned AW    = 12,
  parameter int unsigned SIZE  = 4096
)(
  input  logic                           clk_rom,
  input  logic                           rst_n,
  input  logic                           ioctl_upload,
  input  logic [7:0]                     ioctl_index,
  input  logic                           ioctl_rd,
  input  logic [IOCTL_AW-1:0]            ioctl_addr,
  output logic [(WIDE != 0 ? 16 : 8)-1:0] ioctl_din,
  jtframe_ioctl_upload_if.master         mem,
  output logic                           hold,
  output logic                           busy,
  output logic                           overrun
`ifdef JTFRAME_UPLOAD_SUM_EN
  ,output logic [15:0]                   sum
`endif
);

  localparam int unsigned DW = (WIDE != 0) ? 16 : 8;

  state_t              state, state_n;
  logic                active_c, active_q;
  logic [IOCTL_AW-1:0] addr_q, q_addr, fetch_addr;
  logic                q_valid;
  logic                fetch_start, fetch_abort, fetch_done;
  logic                take_q, load_addr, lo_en, hi_en, din_en;
  logic [7:0]          fetch_data;
  logic [DW-1:0]       word_q;

  assign active_c = ioctl_upload && (ioctl_index == INDEX);

  jtframe_ioctl_fetch #(.AW(AW), .SIZE(SIZE)) u_fetch (
    .clk_rom (clk_rom),
    .rst_n   (rst_n),
    .start   (fetch_start),
    .abort   (fetch_abort),
    .addr    (fetch_addr),
    .data_c  (fetch_data),
    .done_c  (fetch_done),
    .mem     (mem)
  );

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Session end aborts any fetch; a queued request has priority over a fresh strobe
  always_comb begin
    state_n     = state;
    fetch_start = 1'b0;
    fetch_abort = 1'b0;
    fetch_addr  = addr_q;
    take_q      = 1'b0;
    load_addr   = 1'b0;
    lo_en       = 1'b0;
    hi_en       = 1'b0;
    din_en      = 1'b0;
    if (state != IDLE && !active_c) begin
      state_n     = IDLE;
      fetch_abort = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (active_c && q_valid) begin
            fetch_start = 1'b1;
            fetch_addr  = q_addr;
            take_q      = 1'b1;
            load_addr   = 1'b1;
            state_n     = LO;
          end else if (active_c && ioctl_rd) begin
            fetch_start = 1'b1;
            fetch_addr  = ioctl_addr;
            load_addr   = 1'b1;
            state_n     = LO;
          end
        end
        LO: begin
          if (fetch_done) begin
            lo_en = 1'b1;
            if (WIDE != 0) begin
              fetch_start = 1'b1;
              fetch_addr  = addr_q + IOCTL_AW'(1);
              state_n     = HI;
            end else begin
              state_n = DONE;
            end
          end
        end
        HI: begin
          if (fetch_done) begin
            hi_en   = 1'b1;
            state_n = DONE;
          end
        end
        DONE: begin
          din_en  = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      hold      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      addr_q    <= '0;
      q_addr    <= '0;
      q_valid   <= 1'b0;
      word_q    <= '0;
      ioctl_din <= '0;
    end else begin
      active_q <= active_c;
      hold     <= active_q;
      busy     <= (state_n != IDLE);
      if (load_addr) addr_q <= fetch_addr;
      if (lo_en)     word_q[7:0] <= fetch_data;
      if (hi_en)     word_q[DW-1:DW-8] <= fetch_data;
      if (din_en)    ioctl_din <= word_q;
      if (active_c && !active_q) overrun <= 1'b0;
      // One-deep request queue; a strobe that finds it still full is dropped
      if (!active_c) begin
        q_valid <= 1'b0;
      end else begin
        if (take_q) q_valid <= 1'b0;
        if (ioctl_rd && (state != IDLE || q_valid)) begin
          if (q_valid && !take_q) begin
            overrun <= 1'b1;
          end else begin
            q_valid <= 1'b1;
            q_addr  <= ioctl_addr;
          end
        end
      end
    end
  end

`ifdef JTFRAME_UPLOAD_SUM_EN
  logic [15:0] sum_add_c;

  assign sum_add_c = 16'(word_q[7:0]) + ((WIDE != 0) ? 16'(word_q[DW-1:DW-8]) : 16'd0);

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n)                     sum <= 16'd0;
    else if (active_c && !active_q) sum <= 16'd0;
    else if (din_en)                sum <= sum + sum_add_c;
  end
`endif

endmodule

// File: tb/tb_jtframe_ioctl_upload.sv
// Directed bench for jtframe_ioctl_upload: one 8-bit and one 16-bit instance on shared ioctl stimulus.
module tb_jtframe_ioctl_upload;

  logic        clk_rom = 1'b0;
  logic        rst_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd2;
  logic        ioctl_rd = 1'b0;
  logic [26:0] ioctl_addr = '0;

  logic [7:0]  din8;
  logic [15:0] din16;
  logic        hold8, busy8, ovr8, hold16, busy16, ovr16;
`ifdef JTFRAME_UPLOAD_SUM_EN
  logic [15:0] sum8, sum16;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int dly   = 0;
  int w8    = 0;
  int w16   = 0;
  int n16   = 0;
  int base;
  logic [11:0] log16 [0:15];
  logic [7:0]  mem [0:4095];

  jtframe_ioctl_upload_if #(.AW(12)) m8 ();
  jtframe_ioctl_upload_if #(.AW(12)) m16 ();

  jtframe_ioctl_upload #(.WIDE(0), .INDEX(8'd2), .AW(12), .SIZE(4096)) u8 (
    .clk_rom(clk_rom), .rst_n(rst_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din8), .mem(m8),
    .hold(hold8), .busy(busy8), .overrun(ovr8)
`ifdef JTFRAME_UPLOAD_SUM_EN
    , .sum(sum8)
`endif
  );

  jtframe_ioctl_upload #(.WIDE(1), .INDEX(8'd2), .AW(12), .SIZE(4096)) u16 (
    .clk_rom(clk_rom), .rst_n(rst_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din16), .mem(m16),
    .hold(hold16), .busy(busy16), .overrun(ovr16)
`ifdef JTFRAME_UPLOAD_SUM_EN
    , .sum(sum16)
`endif
  );

  always #5 clk_rom = ~clk_rom;

  // Memory models: acknowledge dly+1 cycles after seeing mem_rd
  always @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      m8.mem_ok   <= 1'b0;
      m8.mem_dout <= 8'd0;
      w8          <= 0;
    end else begin
      m8.mem_ok <= 1'b0;
      if (m8.mem_rd && !m8.mem_ok) begin
        if (w8 >= dly) begin
          m8.mem_ok   <= 1'b1;
          m8.mem_dout <= mem[m8.mem_addr];
          w8          <= 0;
        end else begin
          w8 <= w8 + 1;
        end
      end else begin
        w8 <= 0;
      end
    end
  end

  always @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      m16.mem_ok   <= 1'b0;
      m16.mem_dout <= 8'd0;
      w16          <= 0;
    end else begin
      m16.mem_ok <= 1'b0;
      if (m16.mem_rd && !m16.mem_ok) begin
        if (w16 >= dly) begin
          m16.mem_ok       <= 1'b1;
          m16.mem_dout     <= mem[m16.mem_addr];
          w16              <= 0;
          log16[n16 % 16]  <= m16.mem_addr;
          n16              <= n16 + 1;
        end else begin
          w16 <= w16 + 1;
        end
      end else begin
        w16 <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_rom);
  endtask

  task automatic strobe(input logic [26:0] a);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_rom);
    ioctl_rd   = 1'b0;
  endtask

  task automatic wait8(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 200; i++) begin
      if (din8 === exp) break;
      @(negedge clk_rom);
    end
    chk(tag, 32'(din8), 32'(exp));
  endtask

  task automatic wait16(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 200; i++) begin
      if (din16 === exp) break;
      @(negedge clk_rom);
    end
    chk(tag, 32'(din16), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 3 + 1);
    mem[12'h010] = 8'hA5; mem[12'h011] = 8'h5C;
    mem[12'h020] = 8'h34; mem[12'h021] = 8'h12;
    mem[12'hFFF] = 8'hC3;
    mem[12'h040] = 8'h11; mem[12'h041] = 8'h22; mem[12'h042] = 8'h33;
    mem[12'h060] = 8'h01; mem[12'h061] = 8'h02; mem[12'h062] = 8'h03; mem[12'h063] = 8'h04;

    // Reset state
    tick(2);
    chk("rst_din8",     32'(din8), 'h0);
    chk("rst_din16",    32'(din16), 'h0);
    chk("rst_mem_rd",   32'(m8.mem_rd), 'h0);
    chk("rst_mem_addr", 32'(m8.mem_addr), 'h0);
    chk("rst_hold",     32'(hold8), 'h0);
    chk("rst_busy",     32'(busy8), 'h0);
    chk("rst_overrun",  32'(ovr8), 'h0);
    rst_n = 1'b1;
    tick(1);

    // Session start: hold follows the registered session flag one cycle later
    ioctl_upload = 1'b1;
    tick(1);
    chk("hold_delay", 32'(hold8), 'h0);
    tick(1);
    chk("hold_on", 32'(hold8), 'h1);

    // 8-bit read, zero-wait memory: result on the third edge after the strobe
    strobe(27'h10);
    chk("t1_busy_start", 32'(busy8), 'h1);
    chk("t1_mem_rd",     32'(m8.mem_rd), 'h1);
    chk("t1_mem_addr",   32'(m8.mem_addr), 'h10);
    tick(2);
    chk("t1_din_early",  32'(din8), 'h0);
    chk("t1_busy_mid",   32'(busy8), 'h1);
    tick(1);
    chk("t1_din8",       32'(din8), 'hA5);
    chk("t1_busy_end",   32'(busy8), 'h0);
    tick(2);
    chk("t1_din16",      32'(din16), 'h5CA5);

    // 16-bit packing: two memory reads, result on the fifth edge
    base = n16;
    strobe(27'h20);
    tick(3);
    chk("t2_din16_early", 32'(din16), 'h5CA5);
    tick(2);
    chk("t2_din16",   32'(din16), 'h1234);
    chk("t2_reads",   32'(n16 - base), 'h2);
    chk("t2_addr_lo", 32'(log16[base % 16]), 'h20);
    chk("t2_addr_hi", 32'(log16[(base + 1) % 16]), 'h21);
    chk("t2_din8",    32'(din8), 'h34);

    // Last valid byte: high half padded, single memory access
    base = n16;
    strobe(27'hFFF);
    tick(5);
    chk("t3_din16_edge", 32'(din16), 'hFFC3);
    chk("t3_reads_edge", 32'(n16 - base), 'h1);
    chk("t3_din8_edge",  32'(din8), 'hC3);

    // Far out of range: all padding, no memory access
    base = n16;
    strobe(27'h7FFFFFE);
    chk("t3_no_mem_rd", 32'(m16.mem_rd), 'h0);
    tick(4);
    chk("t3_din16_pad", 32'(din16), 'hFFFF);
    chk("t3_din8_pad",  32'(din8), 'hFF);
    chk("t3_reads_pad", 32'(n16 - base), 'h0);

    // Slow memory: one request queued and served in order, the next one overruns
    dly = 9;
    strobe(27'h40);
    tick(2);
    strobe(27'h41);
    tick(2);
    strobe(27'h42);
    chk("t4_ovr8",  32'(ovr8), 'h1);
    chk("t4_ovr16", 32'(ovr16), 'h1);
    chk("t4_busy8", 32'(busy8), 'h1);
    wait8("t4_first8", 8'h11);
    wait8("t4_second8", 8'h22);
    wait16("t4_first16", 16'h2211);
    wait16("t4_second16", 16'h3322);
    tick(20);
    chk("t4_drop8",  32'(din8), 'h22);
    chk("t4_idle8",  32'(busy8), 'h0);
    chk("t4_drop16", 32'(din16), 'h3322);
    chk("t4_idle16", 32'(busy16), 'h0);

    // Session ends mid-fetch
    strobe(27'h50);
    tick(3);
    chk("t5_mem_rd_wait", 32'(m8.mem_rd), 'h1);
    ioctl_upload = 1'b0;
    tick(1);
    chk("t5_mem_rd_drop", 32'(m8.mem_rd), 'h0);
    chk("t5_hold_still",  32'(hold8), 'h1);
    chk("t5_busy_drop",   32'(busy8), 'h0);
    tick(1);
    chk("t5_hold_off",    32'(hold8), 'h0);
    tick(20);
    chk("t5_din8_kept",   32'(din8), 'h22);
    chk("t5_din16_kept",  32'(din16), 'h3322);
    chk("t5_ovr_sticky",  32'(ovr8), 'h1);

    // Strobe outside a session is ignored
    strobe(27'h10);
    chk("t5_ignored_busy", 32'(busy8), 'h0);
    tick(4);
    chk("t5_ignored_din",  32'(din8), 'h22);

    // New session clears overrun
    dly = 0;
    ioctl_upload = 1'b1;
    tick(1);
    chk("t5_ovr8_clear",  32'(ovr8), 'h0);
    chk("t5_ovr16_clear", 32'(ovr16), 'h0);

    // Dump 01 02 03 04
    strobe(27'h60);
    tick(6);
    strobe(27'h62);
    tick(6);
    chk("t6_din16", 32'(din16), 'h0403);
    chk("t6_din8",  32'(din8), 'h03);
`ifdef JTFRAME_UPLOAD_SUM_EN
    chk("t6_sum16", 32'(sum16), 'h000A);
    chk("t6_sum8",  32'(sum8), 'h0004);
`endif

    // Asynchronous reset mid-fetch
    dly = 9;
    strobe(27'h70);
    tick(2);
    chk("t7_mem_rd_pre", 32'(m8.mem_rd), 'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_din8",     32'(din8), 'h0);
    chk("t7_din16",    32'(din16), 'h0);
    chk("t7_mem_rd8",  32'(m8.mem_rd), 'h0);
    chk("t7_mem_rd16", 32'(m16.mem_rd), 'h0);
    chk("t7_mem_addr", 32'(m8.mem_addr), 'h0);
    chk("t7_busy8",    32'(busy8), 'h0);
    chk("t7_busy16",   32'(busy16), 'h0);
    chk("t7_hold8",    32'(hold8), 'h0);
`ifdef JTFRAME_UPLOAD_SUM_EN
    chk("t7_sum16",    32'(sum16), 'h0);
`endif
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
